commit_store_buffer: RTL
========================

COMMIT_STORE_BUFFER -- requirements
Module: commit_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH_SPEC, default 4, speculative queue entries; power of two, at least 2.
REQ-002 SHALL have parameter DEPTH_COMMIT, default 4, committed queue entries; power of two, at least 2.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port flush_i, input, 1, discard all speculative entries.
REQ-006 SHALL have port valid_i, input, 1, push a speculative store.
REQ-007 SHALL have port paddr_i, input, riscv::PLEN, store physical address.
REQ-008 SHALL have port data_i, input, riscv::XLEN, store data.
REQ-009 SHALL have port be_i, input, riscv::XLEN/8, byte enables.
REQ-010 SHALL have port size_i, input, 2, access size.
REQ-011 SHALL have port ready_o, output, 1, speculative queue not full.
REQ-012 SHALL have port commit_i, input, 1, commit-stage request to make the oldest speculative store non-speculative.
REQ-013 SHALL have port commit_ready_o, output, 1, committed queue not full; drives the commit stage's LSU-ready input.
REQ-014 SHALL have port no_st_pending_o, output, 1, both queues empty.
REQ-015 SHALL have port req_o, output, 1, D$ write request.
REQ-016 SHALL have ports req_addr_o/req_data_o/req_be_o/req_size_o, outputs, PLEN/XLEN/XLEN/8/2, head committed entry.
REQ-017 SHALL have port gnt_i, input, 1, D$ grant.
REQ-018 SHALL have port page_offset_i, input, 12, load page offset for hazard check.
REQ-019 SHALL have port page_offset_matches_o, output, 1, pending store to same doubleword.

Function
REQ-020 Speculative queue SHALL be a FIFO; push when valid_i && ready_o; ready_o = (spec_cnt < DEPTH_SPEC), from registered count only.
REQ-021 valid_i while ready_o=0 SHALL be dropped, with no state change and an assertion flagging it.
REQ-022 commit_i with spec_cnt>0 && commit_ready_o SHALL pop spec head and push it to committed tail in the same cycle.
REQ-023 commit_i with spec queue empty or commit_ready_o=0 SHALL be ignored.
REQ-024 commit_ready_o SHALL be (commit_cnt < DEPTH_COMMIT), from registered count; a same-cycle drain pop SHALL NOT be credited.
REQ-025 flush_i SHALL zero the speculative count and pointers next cycle; committed entries SHALL be unaffected.
REQ-026 On a flush_i cycle, commit_i SHALL still be honoured (the entry moves) and valid_i SHALL be dropped.
REQ-027 Simultaneous push and commit SHALL both take effect; spec_cnt stays unchanged.
REQ-028 req_o SHALL be (commit_cnt>0), driven combinationally; req_*_o SHALL show the head entry, stable while req_o && !gnt_i.
REQ-029 On req_o && gnt_i the head SHALL pop; the next entry SHALL be requested the following cycle, giving 1 store/cycle throughput.
REQ-030 Minimum latency: push cycle N, commit_i cycle N+1, req_o cycle N+2.
REQ-031 no_st_pending_o SHALL be (spec_cnt==0 && commit_cnt==0).
REQ-032 Pointers SHALL wrap modulo depth; counts SHALL never exceed depth or underflow.

Reset
REQ-033 rst_i asserted SHALL asynchronously clear all counts and pointers: ready_o=1, commit_ready_o=1, no_st_pending_o=1, req_o=0, page_offset_matches_o=0.
REQ-034 Entry storage SHALL NOT be reset; reset mid-drain SHALL drop req_o immediately and lose all entries.

Configuration
REQ-035 With macro STORE_BUFFER_FWD_EN defined, page_offset_matches_o SHALL be 1 when any valid entry in either queue has paddr[11:3] == page_offset_i[11:3], driven combinationally.
REQ-036 Without STORE_BUFFER_FWD_EN, page_offset_matches_o SHALL be tied 0 and no compare logic instantiated.

Verification
REQ-037 Reset, then push paddr=0x80000010 data=0xDEAD be=0xFF, commit_i next cycle, gnt_i=1 -> req_o at cycle 3 with those values; no_st_pending_o=1 the cycle after grant.
REQ-038 Push 4 stores, no commits -> ready_o=0; 5th valid_i dropped; spec_cnt stays 4.
REQ-039 Push 3, commit 1, flush_i -> committed store still drains; spec queue empty; no_st_pending_o=1 after drain.
REQ-040 Fill committed queue (4) with gnt_i=0 -> commit_ready_o=0 and commit_i ignored; gnt_i=1 for 4 cycles -> 4 back-to-back grants in order.
REQ-041 Pending store paddr=0x1238, page_offset_i=0x23C -> matches_o=1 with STORE_BUFFER_FWD_EN defined, 0 without; page_offset_i=0x240 -> 0 in both builds.
REQ-042 Assert rst_i mid-drain with 2 committed entries -> req_o=0 in the same cycle, all counts 0.

Source files
------------

// File: rtl/commit_store_buffer.sv
// Two-stage store buffer: speculative FIFO feeding a committed FIFO that drains to the D$.
// Optional load/store page-offset hazard compare is enabled with `define STORE_BUFFER_FWD_EN.
module commit_store_buffer #(
  parameter int unsigned DEPTH_SPEC   = 4,
  parameter int unsigned DEPTH_COMMIT = 4,
  parameter int unsigned PLEN         = 56,
  parameter int unsigned XLEN         = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [PLEN-1:0]   paddr_i,
  input  logic [XLEN-1:0]   data_i,
  input  logic [XLEN/8-1:0] be_i,
  input  logic [1:0]        size_i,
  output logic              ready_o,
  input  logic              commit_i,
  output logic              commit_ready_o,
  output logic              no_st_pending_o,
  output logic              req_o,
  output logic [PLEN-1:0]   req_addr_o,
  output logic [XLEN-1:0]   req_data_o,
  output logic [XLEN/8-1:0] req_be_o,
  output logic [1:0]        req_size_o,
  input  logic              gnt_i,
  input  logic [11:0]       page_offset_i,
  output logic              page_offset_matches_o
);

  localparam int unsigned SPW = $clog2(DEPTH_SPEC);
  localparam int unsigned CMW = $clog2(DEPTH_COMMIT);
  localparam logic [SPW:0] SPEC_FULL   = (SPW+1)'(DEPTH_SPEC);
  localparam logic [CMW:0] COMMIT_FULL = (CMW+1)'(DEPTH_COMMIT);

  typedef struct packed {
    logic [PLEN-1:0]   addr;
    logic [XLEN-1:0]   data;
    logic [XLEN/8-1:0] be;
    logic [1:0]        size;
  } entry_t;

  entry_t         spec_mem   [DEPTH_SPEC];
  entry_t         commit_mem [DEPTH_COMMIT];
  logic [SPW-1:0] spec_rd, spec_wr;
  logic [SPW:0]   spec_cnt;
  logic [CMW-1:0] commit_rd, commit_wr;
  logic [CMW:0]   commit_cnt;
  logic           push, commit_go, drain;

  assign ready_o         = spec_cnt < SPEC_FULL;
  assign commit_ready_o  = commit_cnt < COMMIT_FULL;
  assign no_st_pending_o = (spec_cnt == '0) && (commit_cnt == '0);

  // A flush cycle drops any new store but still lets the head commit.
  assign push      = valid_i && ready_o && !flush_i;
  assign commit_go = commit_i && (spec_cnt != '0) && commit_ready_o;
  assign drain     = req_o && gnt_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      spec_rd  <= '0;
      spec_wr  <= '0;
      spec_cnt <= '0;
    end else if (flush_i) begin
      spec_rd  <= '0;
      spec_wr  <= '0;
      spec_cnt <= '0;
    end else begin
      if (push)      spec_wr <= spec_wr + 1'b1;
      if (commit_go) spec_rd <= spec_rd + 1'b1;
      case ({push, commit_go})
        2'b10:   spec_cnt <= spec_cnt + 1'b1;
        2'b01:   spec_cnt <= spec_cnt - 1'b1;
        default: spec_cnt <= spec_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      commit_rd  <= '0;
      commit_wr  <= '0;
      commit_cnt <= '0;
    end else begin
      if (commit_go) commit_wr <= commit_wr + 1'b1;
      if (drain)     commit_rd <= commit_rd + 1'b1;
      case ({commit_go, drain})
        2'b10:   commit_cnt <= commit_cnt + 1'b1;
        2'b01:   commit_cnt <= commit_cnt - 1'b1;
        default: commit_cnt <= commit_cnt;
      endcase
    end
  end

  // Entry payloads are qualified by the counts, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (push)
      spec_mem[spec_wr] <= '{addr: paddr_i, data: data_i, be: be_i, size: size_i};
    if (commit_go)
      commit_mem[commit_wr] <= spec_mem[spec_rd];
  end

  assign req_o      = commit_cnt != '0;
  assign req_addr_o = commit_mem[commit_rd].addr;
  assign req_data_o = commit_mem[commit_rd].data;
  assign req_be_o   = commit_mem[commit_rd].be;
  assign req_size_o = commit_mem[commit_rd].size;

`ifdef STORE_BUFFER_FWD_EN
  logic fwd_hit;
  logic unused_page_lo;

  assign unused_page_lo = ^page_offset_i[2:0];

  always_comb begin
    fwd_hit = 1'b0;
    for (int unsigned k = 0; k < DEPTH_SPEC; k++) begin
      if (((SPW+1)'(k) < spec_cnt) &&
          (spec_mem[spec_rd + SPW'(k)].addr[11:3] == page_offset_i[11:3]))
        fwd_hit = 1'b1;
    end
    for (int unsigned k = 0; k < DEPTH_COMMIT; k++) begin
      if (((CMW+1)'(k) < commit_cnt) &&
          (commit_mem[commit_rd + CMW'(k)].addr[11:3] == page_offset_i[11:3]))
        fwd_hit = 1'b1;
    end
  end

  assign page_offset_matches_o = fwd_hit;
`else
  logic unused_page;

  assign unused_page           = ^page_offset_i;
  assign page_offset_matches_o = 1'b0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i)
      assert (!(valid_i && !ready_o))
        else $warning("commit_store_buffer: store dropped, speculative queue full");
  end
`endif

endmodule
